// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux selection sequencer: FSM state encoding
// and the width of the settle-time hold counter.
package mux_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      OFFER  = 2'd2,
      DONE   = 2'd3
   } seq_state_t;

   localparam int HOLD_W = 8;

endpackage

// File: rtl/hold_counter.sv
// Loadable down-counter with a zero flag. It counts the settle cycles spent
// at each selection code. A load takes priority over a decrement, and the
// count never wraps below zero.
module hold_counter
   import mux_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [HOLD_W-1:0] count;

   // Load or count down, saturating at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Sweeps the select input of a 16:1 mux through a programmed range of codes.
// At each code it waits a settle time, samples the mux output, and offers the
// sample downstream.
// Optional feature: define MUX_SEQ_CHECKSUM_EN to build a running XOR of
// accepted samples on `checksum`. Otherwise `checksum` is tied to zero.
//
// Handshake: a sample transfers on any rising edge where sample_valid and
// sample_ready are both high. While sample_valid is high and the transfer has
// not happened, sample_data and sample_idx hold steady. sample_ready has no
// effect while sample_valid is low.
module mux_sel_sequencer
   import mux_seq_pkg::*;
#(
   parameter int NBITS       = 4,
   parameter int NSEL        = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NSEL-1:0]  first_sel,
   input  logic [NSEL-1:0]  last_sel,
   output logic [NSEL-1:0]  selection,
   input  logic [NBITS-1:0] mux_out,
   output logic             sample_valid,
   output logic [NBITS-1:0] sample_data,
   output logic [NSEL-1:0]  sample_idx,
   input  logic             sample_ready,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] checksum,
   output seq_state_t       dbg_state
);

   // The counter is loaded with HOLD_CYCLES-1 because the edge that leaves
   // SETTLE is itself one of the settle cycles.
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

   seq_state_t       state, state_nx;
   logic [NSEL-1:0]  last_q, last_nx;
   logic [NSEL-1:0]  sel_nx;
   logic             valid_nx;
   logic [NBITS-1:0] data_nx;
   logic [NSEL-1:0]  idx_nx;
   logic             busy_nx;
   logic             done_nx;
   logic             hold_load;
   logic             hold_dec;
   logic             hold_zero;
   logic             handshake;

   assign handshake = sample_valid && sample_ready;
   assign dbg_state = state;

   hold_counter u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (HOLD_LOAD),
      .dec      (hold_dec),
      .zero     (hold_zero)
   );

   // State and output registers. Every output is registered, so a reset
   // clears them all at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_q       <= '0;
         selection    <= '0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_idx   <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nx;
         last_q       <= last_nx;
         selection    <= sel_nx;
         sample_valid <= valid_nx;
         sample_data  <= data_nx;
         sample_idx   <= idx_nx;
         busy         <= busy_nx;
         done         <= done_nx;
      end
   end

   // Next-state and next-output logic. Only the last code is kept from the
   // start request, because `selection` itself carries the first code.
   always_comb begin
      state_nx  = state;
      last_nx   = last_q;
      sel_nx    = selection;
      valid_nx  = sample_valid;
      data_nx   = sample_data;
      idx_nx    = sample_idx;
      busy_nx   = busy;
      done_nx   = 1'b0;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               last_nx   = last_sel;
               sel_nx    = first_sel;
               busy_nx   = 1'b1;
               hold_load = 1'b1;
               state_nx  = SETTLE;
            end
         end
         SETTLE: begin
            if (hold_zero) begin
               data_nx  = mux_out;
               idx_nx   = selection;
               valid_nx = 1'b1;
               state_nx = OFFER;
            end else begin
               hold_dec = 1'b1;
            end
         end
         OFFER: begin
            if (handshake) begin
               valid_nx = 1'b0;
               if (selection == last_q) begin
                  done_nx  = 1'b1;
                  state_nx = DONE;
               end else begin
                  sel_nx    = selection + 1'b1;
                  hold_load = 1'b1;
                  state_nx  = SETTLE;
               end
            end
         end
         DONE: begin
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

`ifdef MUX_SEQ_CHECKSUM_EN
   logic [NBITS-1:0] cs_q;

   // Running XOR of accepted samples, cleared by each accepted start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q <= '0;
      end else if ((state == IDLE) && start) begin
         cs_q <= '0;
      end else if ((state == OFFER) && handshake) begin
         cs_q <= cs_q ^ sample_data;
      end
   end

   assign checksum = cs_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Upstream control stage for the 16:1 N-bit selection mux. On a start pulse it walks the mux `selection` input through a programmed range of codes. At each code it waits a fixed settle time, samples the mux output, and offers the sample downstream over a valid/ready handshake. The block lets the datapath sweep all mux inputs without manual switching of `selection`.

## Interface
Parameters:
- `NBITS`, 4, data width of the mux output being sampled.
- `NSEL`, 4, selection width (2^NSEL mux inputs).
- `HOLD_CYCLES`, 8, settle cycles per code before sampling; legal range is 1..255.

Ports:
- `clk`, in, 1, single clock; all logic is on the rising edge.
- `rst`, in, 1, reset, asynchronous, active-high.
- `start`, in, 1, single-cycle request to begin a sweep. Sampled only in IDLE.
- `first_sel`, in, NSEL, first code of the sweep. Latched on an accepted `start`.
- `last_sel`, in, NSEL, last code of the sweep. Latched on an accepted `start`.
- `selection`, out, NSEL, drives the mux select input.
- `mux_out`, in, NBITS, the mux output (`nOUT`).
- `sample_valid`, out, 1, a sample is being offered.
- `sample_data`, out, NBITS, the sampled mux value.
- `sample_idx`, out, NSEL, the code that produced `sample_data`.
- `sample_ready`, in, 1, downstream accepts the sample.
- `busy`, out, 1, high from an accepted `start` through the DONE state.
- `done`, out, 1, single-cycle pulse when the sweep completes.
- `checksum`, out, NBITS, running XOR of accepted samples. See Configuration.

## Operation
- Reset value of every output is 0: `selection`, `sample_valid`, `sample_data`, `sample_idx`, `busy`, `done`, `checksum`. The FSM resets to IDLE.
- FSM states and transitions:
  - IDLE: on `start`, latch `first_sel`/`last_sel`, load `selection` with `first_sel`, load the hold counter with HOLD_CYCLES-1, go to SETTLE.
  - SETTLE: decrement the hold counter. When it reaches 0, register `mux_out` into `sample_data`, copy `selection` into `sample_idx`, set `sample_valid`, go to OFFER.
  - OFFER: hold all sample outputs stable until `sample_valid` and `sample_ready` are both high. On that handshake, clear `sample_valid`. If `selection` equals the latched last code, go to DONE. Otherwise increment `selection` modulo 2^NSEL, reload the hold counter, and go to SETTLE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Wrap-around: if `last_sel` is less than `first_sel`, the sweep continues through 2^NSEL-1 to 0. Sweep length is ((last-first) mod 2^NSEL)+1. If `first_sel` equals `last_sel`, exactly one sample is taken.
- `start` is ignored when not in IDLE. Changes to `first_sel`/`last_sel` during a sweep have no effect.
- `selection` holds its last value in IDLE and DONE.
- `rst` asserted mid-sweep immediately returns all outputs to reset values. A sample in flight is dropped and no `done` pulse is produced.

## Timing
- `start` is high at edge k. At edge k+1, `selection` = first code and `busy` = 1.
- `sample_valid` rises HOLD_CYCLES cycles after `selection` changes. `sample_data` equals the `mux_out` value present in the cycle before `sample_valid` rises.
- If the handshake occurs at edge h, the new `selection` appears at edge h+1. The next sample follows HOLD_CYCLES cycles later.
- With `sample_ready` tied high, a sweep of L codes is L·(HOLD_CYCLES+1)+1 cycles from `start` to `done`. `busy` falls in the cycle after `done`.
- `sample_ready` may be high before `sample_valid` rises; it has no effect while `sample_valid` is low.

## Configuration
- Macro: `MUX_SEQ_CHECKSUM_EN`.
- Defined: `checksum` clears to 0 on an accepted `start`. It XORs in `sample_data` on every handshake, and holds its value after `done` until the next `start`.
- Undefined: no checksum register is built, and `checksum` is tied to 0.

## Structure
- Shared package `mux_seq_pkg` holds:
  - the state enum `seq_state_t` (IDLE, SETTLE, OFFER, DONE);
  - the hold-counter width constant HOLD_W = 8.
- One sub-module, `hold_counter`: a loadable down-counter with a zero flag, used by SETTLE. All other logic stays in the top module.

## Test plan
- Full sweep: NBITS=4, HOLD_CYCLES=2, mux inputs set to code+3, ready high, first=0, last=15. Required: 16 samples with idx 0..15 and data 3,4,…,15,0,1,2, then `done` 49 cycles after `start`.
- Wrap: first=14, last=1. Required: idx sequence 14,15,0,1, then `done`.
- Single code: first=last=5, mux input 5 = 4'hA. Required: exactly one sample (5, A) and one `done` pulse.
- Backpressure: ready held low for 7 cycles after the first `sample_valid`. Required: `sample_data`/`sample_idx` stable throughout, `selection` unchanged, and advance exactly one cycle after ready rises.
- Reset mid-sweep: assert `rst` while in OFFER. Required: all outputs 0 immediately and no `done`. A new `start` after release runs a full sweep.
- Checksum (macro defined): sweep 0..3 with data 1,2,4,8. Required: `checksum` = 4'hF after `done`. A second `start` clears it to 0.
